// File: rtl/alu_mul_sequencer.sv
// Shares the EXE-stage ALU between the pipeline and an iterative shift-add multiplier.
// Optional feature macro: ALU_SEQ_EARLY_TERM_EN (ends the multiply once the multiplier is exhausted).
module alu_mul_sequencer #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CNT_W   = 6,
    parameter logic [3:0]  CMD_SUM = 4'b0010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pipe_val1,
    input  logic [WIDTH-1:0] pipe_val2,
    input  logic [3:0]       pipe_exe_cmd,
    input  logic             pipe_carry,
    input  logic             mul_start,
    input  logic [WIDTH-1:0] mul_op_a,
    input  logic [WIDTH-1:0] mul_op_b,
    input  logic [WIDTH-1:0] alu_res,
    input  logic [3:0]       alu_status,
    output logic [WIDTH-1:0] alu_val1,
    output logic [WIDTH-1:0] alu_val2,
    output logic [3:0]       alu_exe_cmd,
    output logic             alu_carry_in,
    output logic [3:0]       pipe_status,
    output logic             stall,
    output logic             mul_busy,
    output logic             mul_done,
    output logic [WIDTH-1:0] mul_result,
    output logic [3:0]       mul_status
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;
    logic             last_iter;

`ifdef ALU_SEQ_EARLY_TERM_EN
    // An exhausted multiplier contributes nothing further, so the multiply can finish early.
    assign last_iter = (cnt == CNT_W'(WIDTH - 1)) || (mplier == '0);
`else
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        alu_val1     = pipe_val1;
        alu_val2     = pipe_val2;
        alu_exe_cmd  = pipe_exe_cmd;
        alu_carry_in = pipe_carry;
        pipe_status  = '0;
        stall        = 1'b0;
        mul_busy     = 1'b0;
        mul_done     = 1'b0;
        unique case (state)
            S_IDLE: begin
                pipe_status = alu_status;
                if (mul_start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                alu_val1     = acc;
                alu_val2     = mcand;
                alu_exe_cmd  = CMD_SUM;
                alu_carry_in = 1'b0;
                stall        = 1'b1;
                mul_busy     = 1'b1;
                if (last_iter) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                alu_val1     = '0;
                alu_val2     = '0;
                alu_exe_cmd  = CMD_SUM;
                alu_carry_in = 1'b0;
                stall        = 1'b1;
                mul_busy     = 1'b1;
                mul_done     = 1'b1;
                state_next   = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: the ALU sum output is folded back into acc only for set multiplier bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
            mul_result <= '0;
            mul_status <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (mul_start) begin
                        acc    <= '0;
                        mcand  <= mul_op_a;
                        mplier <= mul_op_b;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    if (mplier[0]) begin
                        acc <= alu_res;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                S_DONE: begin
                    mul_result <= acc;
                    mul_status <= {acc[WIDTH-1], acc == '0, 2'b00};
                end
                default: begin
                end
            endcase
        end
    end

endmodule
